console_sequencer_p: RTL
========================

// Module: console_sequencer_p
// PURPOSE
//  Parametrised successor to the board console FSM. Turns slide-switch entries and
//  button presses into datapath instruction words {A_addr, B_addr, Opc, W_addr, WE}.
//  Adds per-button debounce, one-cycle issue pulses and per-opcode skipping of the
//  write-back step. Sits between the board I/O pins and the RAM/ALU datapath.
// PARAMETERS
//  ADDR_W     4         width of the A, B and W address fields; also the data-entry width
//  OPC_W      3         width of the opcode field
//  SW_W       4         slide-switch width; must be >= ADDR_W, >= OPC_W and >= 3
//  DEB_CYC    4         consecutive stable cycles needed to accept a press or a release (>=1)
//  NO_WB_MASK 8'h30     bit k set: opcode k has no W entry step (default skips MUL/DIV, opc 4,5)
// PORTS
//  CLK_In       in   1                  system clock, rising edge
//  nRST_In      in   1                  asynchronous active-low reset
//  User_Input0  in   SW_W               slide switches
//  User_Input1  in   4                  buttons; 4'b0001 = ENTER, 4'b1000 = ABORT
//  Instruction  out  3*ADDR_W+OPC_W+1   {A, B, Opc, W, WE}
//  Instr_Valid  out  1                  one-cycle pulse when a WE=1 word is first driven
//  State        out  4                  current state encoding (drives the state LEDs)
// BEHAVIOUR
//  Reset: Instruction=0, Instr_Valid=0, State=IDLE. All latched fields and debounce
//   counters clear to 0. Reset mid-entry discards every partial field.
//  Debounce: a press is accepted when User_Input1 holds the same one-hot nonzero value
//   for DEB_CYC cycles. Non-one-hot values and buttons 1-2 are ignored and restart the
//   count. After any accepted press the FSM enters WAIT_REL, and leaves it only after
//   User_Input1==0 for DEB_CYC cycles. Exactly one action per physical press.
//  ABORT: accepted from any state, including WAIT_REL. Sets the pending state to IDLE
//   and overrides any pending transition. Instruction keeps its last value until IDLE.
//  ECHO word = {0, User_Input0[ADDR_W-1:0], 0, 0, 0}. It is driven every cycle in the
//   entry states IDLE, DSAVE_A, DSAVE_D, DREAD_A, I_A, I_B, I_OP and I_W.
//  States (encoding) and transitions on ENTER:
//   WAIT_REL(0): hold Instruction, then go to the pending state.
//   IDLE(1): User_Input0[3:1] one-hot selects the next state: 3'b001 -> DSAVE_A,
//    3'b010 -> DREAD_A, 3'b100 -> I_A. Any other value stays in IDLE.
//   DSAVE_A(2): latch tAddr. -> DSAVE_D.
//   DSAVE_D(3): drive {0, data, 0, tAddr, 1} for exactly 1 cycle with Instr_Valid=1,
//    then ECHO. -> DSAVE_SHOW.
//   DSAVE_SHOW(4), DREAD_SHOW(6): drive {tAddr, 0, 0, 0, 0}. -> IDLE.
//   DREAD_A(5): latch tAddr. -> DREAD_SHOW.
//   I_A(8): latch A. -> I_B.   I_B(9): latch B. -> I_OP.
//   I_OP(10): latch Opc = User_Input0[OPC_W-1:0]. If NO_WB_MASK[Opc] is set, W=0 and
//    WE=0 and -> I_ISSUE; otherwise -> I_W.
//   I_W(12): latch W = User_Input0[ADDR_W:1] and WE = User_Input0[0]. -> I_ISSUE.
//   I_ISSUE(14): no button needed. Drive {A, B, Opc, W, WE} for 1 cycle;
//    Instr_Valid = WE. -> I_SHOW.
//   I_SHOW(15): WE is forced 0 so the write is never repeated. If the issued WE=1 and
//    W==A or W==B (operand overwritten), drive {0, W, 0, 0, 0} to display the result;
//    otherwise drive {A, B, Opc, W, 0}. ENTER -> IDLE.
//  Every ENTER transition passes through WAIT_REL. State reflects WAIT_REL while
//   waiting for the release.
//  Instr_Valid is never high for two consecutive cycles and is 0 in every other case.
//  Field widths: extra switch bits above the field width are ignored. All comparisons
//   are unsigned, ADDR_W wide.
// TESTING
//  T1 Save: sel 4'b0010, addr 5, data 9, ENTER each -> one cycle of {0,9,0,5,1} with
//   Instr_Valid=1, then DSAVE_SHOW drives {5,0,0,0,0}.
//  T2 Bounce: ENTER toggles on/off 3 times within DEB_CYC-1 cycles, then holds ->
//   exactly one transition; a 2-cycle glitch with DEB_CYC=4 -> no transition.
//  T3 MUL skip: A=2, B=3, opc 4 -> I_W is never entered; I_ISSUE drives
//   {2,3,4,0,0} and Instr_Valid stays 0.
//  T4 Hazard: A=2, B=3, opc 1, W=2, WE=1 -> I_ISSUE drives {2,3,1,2,1} with a
//   1-cycle pulse; I_SHOW then drives {0,2,0,0,0} steadily.
//  T5 Abort: ABORT held during I_B, and ABORT during WAIT_REL -> IDLE after release;
//   no Instr_Valid pulse.
//  T6 Reset: assert nRST_In mid-I_W, async to the clock -> all outputs are 0 and
//   State=1 immediately; the next entry starts clean.

Source files
------------

// File: rtl/console_sequencer_p.sv
// Board console sequencer.
// Turns slide-switch entries and debounced button presses into datapath
// instruction words {A, B, Opc, W, WE}. It issues a one-cycle Instr_Valid pulse
// for each word with WE=1. Opcodes flagged in NO_WB_MASK skip the write-back
// entry step.
module console_sequencer_p #(
    parameter int unsigned            ADDR_W     = 4,
    parameter int unsigned            OPC_W      = 3,
    parameter int unsigned            SW_W       = 4,
    parameter int unsigned            DEB_CYC    = 4,
    parameter logic [(1<<OPC_W)-1:0]  NO_WB_MASK = 8'h30
) (
    input  logic                      CLK_In,
    input  logic                      nRST_In,
    input  logic [SW_W-1:0]           User_Input0,
    input  logic [3:0]                User_Input1,
    output logic [3*ADDR_W+OPC_W:0]   Instruction,
    output logic                      Instr_Valid,
    output logic [3:0]                State
);

    localparam int unsigned IW    = 3*ADDR_W + OPC_W + 1;
    localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYC);

    localparam logic [3:0] BTN_ENTER = 4'b0001;
    localparam logic [3:0] BTN_ABORT = 4'b1000;

    typedef enum logic [3:0] {
        S_WAIT_REL   = 4'd0,
        S_IDLE       = 4'd1,
        S_DSAVE_A    = 4'd2,
        S_DSAVE_D    = 4'd3,
        S_DSAVE_SHOW = 4'd4,
        S_DREAD_A    = 4'd5,
        S_DREAD_SHOW = 4'd6,
        S_I_A        = 4'd8,
        S_I_B        = 4'd9,
        S_I_OP       = 4'd10,
        S_I_W        = 4'd12,
        S_I_ISSUE    = 4'd14,
        S_I_SHOW     = 4'd15
    } state_e;

    // Pack the instruction fields in output order.
    function automatic logic [IW-1:0] pack(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b,
        input logic [OPC_W-1:0]  o,
        input logic [ADDR_W-1:0] w,
        input logic              we
    );
        return {a, b, o, w, we};
    endfunction

    // ------------------------------------------------------------------
    // Button debounce
    // ------------------------------------------------------------------
    logic [3:0]       btn_q;
    logic [CNT_W-1:0] run_q, run_d;
    logic             same_btn, deb_hit, enter_ev, abort_ev, rel_ok;

    // Track how long the button value has been stable. The count saturates at
    // DEB_CYC, so an accept fires only once per hold.
    assign same_btn = (User_Input1 == btn_q);

    always_comb begin
        run_d = CNT_W'(1);
        if (same_btn) begin
            run_d = (run_q == DEB_MAX) ? run_q : run_q + 1'b1;
        end
    end

    assign deb_hit  = (run_d == DEB_MAX) && !(same_btn && (run_q == DEB_MAX));
    assign enter_ev = deb_hit && (User_Input1 == BTN_ENTER);
    assign abort_ev = deb_hit && (User_Input1 == BTN_ABORT);
    assign rel_ok   = (User_Input1 == 4'b0000) && (run_d == DEB_MAX);

    // Register the last sampled button value and its stable-run length.
    always_ff @(posedge CLK_In or negedge nRST_In) begin
        if (!nRST_In) begin
            btn_q <= '0;
            run_q <= '0;
        end else begin
            btn_q <= User_Input1;
            run_q <= run_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_e            state_q, state_d, pend_q, pend_d;
    logic [ADDR_W-1:0] taddr_q, taddr_d;
    logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, w_q, w_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic              we_q, we_d;
    logic [IW-1:0]     instr_q, instr_d;
    logic              vld_q, vld_d;
    logic              wr_now;

    // Switch bank zero-extended by one bit so that the W field
    // (switches [ADDR_W:1]) stays in range when SW_W == ADDR_W.
    logic [SW_W:0]     sw_x;
    logic [ADDR_W-1:0] sw_addr, sw_w, shown_b;
    logic [OPC_W-1:0]  sw_opc;
    logic [2:0]        sw_sel;

    assign sw_x    = {1'b0, User_Input0};
    assign sw_addr = sw_x[ADDR_W-1:0];
    assign sw_w    = sw_x[ADDR_W:1];
    assign sw_opc  = sw_x[OPC_W-1:0];
    assign sw_sel  = sw_x[3:1];
    assign shown_b = instr_q[ADDR_W+OPC_W+1 +: ADDR_W];

    // Next state, latched fields, and the word that goes on the pins in the
    // state being entered.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        taddr_d = taddr_q;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        opc_d   = opc_q;
        we_d    = we_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        wr_now  = 1'b0;

        if (abort_ev) begin
            // ABORT wins from anywhere, including a pending release.
            state_d = S_WAIT_REL;
            pend_d  = S_IDLE;
        end else begin
            case (state_q)
                S_WAIT_REL: if (rel_ok) state_d = pend_q;
                S_I_ISSUE:  state_d = S_I_SHOW;
                S_IDLE: if (enter_ev) begin
                    state_d = S_WAIT_REL;
                    case (sw_sel)
                        3'b001:  pend_d = S_DSAVE_A;
                        3'b010:  pend_d = S_DREAD_A;
                        3'b100:  pend_d = S_I_A;
                        default: pend_d = S_IDLE;
                    endcase
                end
                S_DSAVE_A: if (enter_ev) begin
                    taddr_d = sw_addr;
                    state_d = S_WAIT_REL;
                    pend_d  = S_DSAVE_D;
                end
                S_DSAVE_D: if (enter_ev) begin
                    wr_now  = 1'b1;
                    state_d = S_WAIT_REL;
                    pend_d  = S_DSAVE_SHOW;
                end
                S_DREAD_A: if (enter_ev) begin
                    taddr_d = sw_addr;
                    state_d = S_WAIT_REL;
                    pend_d  = S_DREAD_SHOW;
                end
                S_I_A: if (enter_ev) begin
                    a_d     = sw_addr;
                    state_d = S_WAIT_REL;
                    pend_d  = S_I_B;
                end
                S_I_B: if (enter_ev) begin
                    b_d     = sw_addr;
                    state_d = S_WAIT_REL;
                    pend_d  = S_I_OP;
                end
                S_I_OP: if (enter_ev) begin
                    opc_d   = sw_opc;
                    state_d = S_WAIT_REL;
                    if (NO_WB_MASK[sw_opc]) begin
                        w_d    = '0;
                        we_d   = 1'b0;
                        pend_d = S_I_ISSUE;
                    end else begin
                        pend_d = S_I_W;
                    end
                end
                S_I_W: if (enter_ev) begin
                    w_d     = sw_w;
                    we_d    = sw_x[0];
                    state_d = S_WAIT_REL;
                    pend_d  = S_I_ISSUE;
                end
                S_DSAVE_SHOW, S_DREAD_SHOW, S_I_SHOW: if (enter_ev) begin
                    state_d = S_WAIT_REL;
                    pend_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_WAIT_REL: begin
                if (wr_now) begin
                    // The memory write is shown for a single cycle.
                    instr_d = pack('0, sw_addr, '0, taddr_q, 1'b1);
                    vld_d   = 1'b1;
                end else if (vld_q) begin
                    // After a pulse, drop back to the echo of the written data.
                    instr_d = pack('0, shown_b, '0, '0, 1'b0);
                end
            end
            S_DSAVE_SHOW, S_DREAD_SHOW:
                instr_d = pack(taddr_d, '0, '0, '0, 1'b0);
            S_I_ISSUE: begin
                instr_d = pack(a_d, b_d, opc_d, w_d, we_d);
                vld_d   = we_d;
            end
            S_I_SHOW: begin
                // Show the result when the write clobbered one of its own operands.
                if (we_d && ((w_d == a_d) || (w_d == b_d)))
                    instr_d = pack('0, w_d, '0, '0, 1'b0);
                else
                    instr_d = pack(a_d, b_d, opc_d, w_d, 1'b0);
            end
            default:
                instr_d = pack('0, sw_addr, '0, '0, 1'b0);
        endcase
    end

    // State, latched fields, and registered outputs.
    always_ff @(posedge CLK_In or negedge nRST_In) begin
        if (!nRST_In) begin
            state_q <= S_IDLE;
            pend_q  <= S_IDLE;
            taddr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            opc_q   <= '0;
            we_q    <= 1'b0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            taddr_q <= taddr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            opc_q   <= opc_d;
            we_q    <= we_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    assign Instruction = instr_q;
    assign Instr_Valid = vld_q;
    assign State       = state_q;

endmodule
